fetch_sequencer: RTL and testbench

//   Sequences instruction fetch: owns the fetch PC and issues req/gnt requests to instruction memory.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 59 +++++
 rtl/fetch_sequencer.sv | 122 ++++++++++++
 tb/tb_fetch_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned INSTR_W    = 32;

    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_VECTOR = '0;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0]    instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {instr, pc} entries with a flush input.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    output fetch_entry_t     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot in the same cycle, so push-while-full is legal with a pop.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (!reset_n || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC, issues single-outstanding req/gnt fetches and buffers
// returned words toward decode; handles IEU redirects and stale responses.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN         = FETCH_XLEN,
    parameter int unsigned     BUF_DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pcplus4,
    input  logic            instr_ready
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state_q;
    fetch_state_t     state_d;
    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic [XLEN-1:0]  req_pc_q;
    logic [XLEN-1:0]  req_pc_d;
    logic             req_c;
    logic             push_c;
    logic             pop_c;
    logic [CNT_W-1:0] buf_count;
    logic             buf_full;
    logic             buf_empty;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_VECTOR;
            req_pc_q <= RESET_VECTOR;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    // Next state, fetch PC and buffer push; a redirect overrides everything.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        req_c    = 1'b0;
        push_c   = 1'b0;
        unique case (state_q)
            FETCH: begin
                req_c = (buf_count < CNT_W'(BUF_DEPTH)) && !redirect_valid && reset_n;
                if (req_c && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + XLEN'(4);
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push_c  = !redirect_valid;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (imem_rvalid) begin
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(1);
        end
    end

    assign imem_req   = req_c;
    assign imem_addr  = pc_q;
    assign pop_c      = instr_valid && instr_ready;
    assign push_entry = '{instr: imem_rdata, pc: req_pc_q};

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (redirect_valid),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .head_o      (head),
        .count_o     (buf_count),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign instr_valid   = !buf_empty && reset_n;
    assign instr         = head.instr;
    assign instr_pc      = head.pc;
    assign instr_pcplus4 = head.pc + XLEN'(4);

    a_rvalid_expected: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> (state_q != FETCH));

    a_push_has_room: assert property (@(posedge clk) disable iff (!reset_n)
        push_c |-> (!buf_full || pop_c));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small req/gnt/rvalid memory model.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    // memory model knobs and state
    int          gnt_dly  = 0;
    int          rsp_lat  = 1;
    logic        drop_rsp = 1'b0;
    int          wait_cnt = 0;
    logic        pend     = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;

    fetch_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pcplus4  (instr_pcplus4),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    // Memory: gnt after gnt_dly waiting cycles, in-order response rsp_lat cycles after gnt.
    always @(posedge clk) begin
        if (imem_rvalid) pend = 1'b0;
        if (drop_rsp) pend = 1'b0;
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_cnt  = rsp_lat - 1;
            pend_addr = imem_addr;
            wait_cnt  = 0;
        end else begin
            if (pend && pend_cnt > 0) pend_cnt = pend_cnt - 1;
            wait_cnt = imem_req ? wait_cnt + 1 : 0;
        end
        #1;
        imem_gnt    = (wait_cnt >= gnt_dly);
        imem_rvalid = pend && (pend_cnt == 0);
        imem_rdata  = pend ? (pend_addr ^ KEY) : 32'hBAD0_BAD0;
    end

    typedef struct {
        logic        rst_n;
        logic        ready;
        int          gdly;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic rdy, input int g, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ep);
        vec_t v;
        v.rst_n = r; v.ready = rdy; v.gdly = g;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        vecs.push_back(v);
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got=%h want=%h", tag, what, act, exp);
        end
    endtask

    task automatic check(input string tag, input logic ereq, input logic [31:0] eaddr,
                         input logic ev, input logic [31:0] epc);
        cmp(tag, "imem_req", 32'(imem_req), 32'(ereq));
        if (ereq) cmp(tag, "imem_addr", imem_addr, eaddr);
        cmp(tag, "instr_valid", 32'(instr_valid), 32'(ev));
        if (ev) begin
            cmp(tag, "instr_pc", instr_pc, epc);
            cmp(tag, "instr", instr, epc ^ KEY);
            cmp(tag, "instr_pcplus4", instr_pcplus4, epc + 32'd4);
        end
    endtask

    task automatic step(input logic rst, input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        reset_n        = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
    endtask

    initial begin
        // reset
        add(0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0);
        // sequential fetch, zero-wait gnt, 1-cycle response
        add(1, 1, 0, 1, 32'h0, 0, 0);
        add(1, 1, 0, 0, 0,     0, 0);
        add(1, 1, 0, 1, 32'h4, 1, 32'h0);
        add(1, 1, 0, 0, 0,     0, 0);
        add(1, 1, 0, 1, 32'h8, 1, 32'h4);
        add(1, 1, 0, 0, 0,     0, 0);
        add(1, 1, 0, 1, 32'hC, 1, 32'h8);
        // decode stalled: buffer fills to two entries, then drains in order
        add(0, 0, 0, 0, 0,     0, 0);
        add(1, 0, 0, 1, 32'h0, 0, 0);
        add(1, 0, 0, 0, 0,     0, 0);
        add(1, 0, 0, 1, 32'h4, 1, 32'h0);
        add(1, 0, 0, 0, 0,     1, 32'h0);
        add(1, 0, 0, 0, 0,     1, 32'h0);
        add(1, 0, 0, 0, 0,     1, 32'h0);
        add(1, 1, 0, 0, 0,     1, 32'h0);
        add(1, 1, 0, 1, 32'h8, 1, 32'h4);
        add(1, 1, 0, 0, 0,     0, 0);
        // grant delayed by three cycles: request held on 0x10
        add(1, 1, 3, 1, 32'hC,  1, 32'h8);
        add(1, 1, 3, 0, 0,      0, 0);
        add(1, 1, 3, 1, 32'h10, 1, 32'hC);
        add(1, 1, 3, 1, 32'h10, 0, 0);
        add(1, 1, 3, 1, 32'h10, 0, 0);
        add(1, 1, 3, 1, 32'h10, 0, 0);
        add(1, 1, 3, 0, 0,      0, 0);
        add(1, 1, 3, 1, 32'h14, 1, 32'h10);
        add(1, 1, 0, 1, 32'h14, 0, 0);
        add(1, 1, 0, 1, 32'h14, 0, 0);
        add(1, 1, 0, 0, 0,      0, 0);
        add(1, 1, 0, 1, 32'h18, 1, 32'h14);

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, 1'b0, 32'h0, vecs[i].ready);
            gnt_dly = vecs[i].gdly;
            check($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_valid, vecs[i].exp_pc);
        end
        gnt_dly = 0;
        rsp_lat = 1;

        // redirect while waiting on 0x8; stale response arrives later and is dropped
        step(0, 0, 0, 1); check("r4_rst", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r4_c1", 1, 32'h0, 0, 0);
        step(1, 0, 0, 1); check("r4_c2", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r4_c3", 1, 32'h4, 1, 32'h0);
        step(1, 0, 0, 1); check("r4_c4", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r4_c5", 1, 32'h8, 1, 32'h4);
        rsp_lat = 3;
        step(1, 1, 32'h201, 1); check("r4_redir", 0, 0, 0, 0);
        rsp_lat = 1;
        step(1, 0, 0, 1); check("r4_disc", 0, 0, 0, 0);
        cmp("r4_disc", "imem_addr", imem_addr, 32'h200);
        step(1, 0, 0, 1); check("r4_stale", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r4_tgt", 1, 32'h200, 0, 0);
        step(1, 0, 0, 1); check("r4_wait", 0, 0, 0, 0);

        // redirect coincident with rvalid and with a pop of the head
        step(1, 0, 0, 0); check("r5_hold", 1, 32'h204, 1, 32'h200);
        step(1, 1, 32'h300, 1); check("r5_redir", 0, 0, 1, 32'h200);
        step(1, 0, 0, 1); check("r5_tgt", 1, 32'h300, 0, 0);
        step(1, 0, 0, 1); check("r5_wait", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r5_head", 1, 32'h304, 1, 32'h300);

        // redirect to the top of the address space, wrap, then reset mid-WAIT
        step(1, 1, 32'hFFFF_FFFD, 1); check("r6_redir", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r6_top", 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 0, 0, 1); check("r6_wait", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r6_wrap", 1, 32'h0, 1, 32'hFFFF_FFFC);
        rsp_lat = 3;
        step(0, 0, 0, 1); check("r6_rst", 0, 0, 0, 0);
        drop_rsp = 1'b1;
        rsp_lat  = 1;
        step(1, 0, 0, 1); check("r6_restart", 1, 32'h0, 0, 0);
        drop_rsp = 1'b0;
        step(1, 0, 0, 1); check("r6_wait2", 0, 0, 0, 0);
        step(1, 0, 0, 1); check("r6_head", 1, 32'h4, 1, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
